seg_display_decoder: RTL and testbench
======================================

Name: seg_display_decoder

Overview:
- Receive-side counterpart of the two-digit multiplexed 7-segment driver.
- Watches the segment bus (digit_seg) and digit-select (digit_con) and reconstructs the displayed decimal value (00-99) as BCD and binary.
- Detects illegal segment patterns and raises an error.
- Used as a loopback monitor or as a front end for boards that read another board's display bus.

Parameters:
- SETTLE_CYCLES, 2: clk cycles that the synchronised select and segments must hold unchanged before a digit is sampled (range 1-15).
- STABLE_FRAMES, 4: consecutive identical complete frames needed before the output value is committed (range 1-15).

Ports:
- clk  in  1  system clock; all logic on posedge.
- res_n  in  1  asynchronous active-low reset.
- digit_seg  in  8  segment bus, bit7=a … bit1=g, bit0=dp; active-high.
- digit_con  in  2  digit select: 2'b10 = tens, 2'b01 = ones, 00/11 = blank.
- tens  out  4  committed tens digit, BCD.
- ones  out  4  committed ones digit, BCD.
- value  out  7  committed value, binary, equal to tens*10+ones.
- valid  out  1  high once at least one value has been committed.
- update  out  1  one-cycle pulse when the committed value changes.
- seg_err  out  1  one-cycle pulse when an illegal pattern is sampled.
- err_count  out  8  saturating count of seg_err pulses.

Behaviour:
- Reset (res_n low, asynchronous): every output is 0, the FSM is in WAIT_T, and the synchronisers, candidate, match counter and settle counter are cleared.
- Input capture:
  - digit_seg and digit_con pass through 2-flop synchronisers (inputs are asynchronous to clk).
  - All further logic uses the synchronised copies.
  - dp (bit0) is ignored.
- Segment decode, a..g to digit: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9. Any other pattern is illegal.
- Settle counter:
  - Resets to 0 whenever the synced select or a..g differs from its value on the previous cycle.
  - Otherwise increments, saturating at SETTLE_CYCLES.
  - A digit is "sampled" in the cycle the counter reaches SETTLE_CYCLES.
- FSM states:
  - WAIT_T: wait for select=10, then go to SET_T. Select=01 is ignored here, so every frame starts with tens.
  - SET_T: on sample, latch cand_t and go to WAIT_O. If select leaves 10 before the sample, return to WAIT_T.
  - WAIT_O: on select=01, go to SET_O. On 00/11, go to WAIT_T and discard the partial frame. Select=10 stays in WAIT_O.
  - SET_O: on sample, latch cand_o, evaluate the frame, and go to WAIT_T. If select leaves 01 before the sample, return to WAIT_T.
- Frame evaluation, in the cycle cand_o is sampled:
  - If {cand_t, cand_o} equals the previous frame, match_cnt increments (saturating at STABLE_FRAMES).
  - Otherwise the new frame is stored and match_cnt = 1.
  - When match_cnt reaches STABLE_FRAMES:
    - tens, ones and value load the next cycle, and valid goes to 1.
    - update pulses that same cycle only if the new value differs from the currently committed one or valid was 0.
  - A repeated identical value commits nothing new and gives no update.
- Illegal pattern sampled in SET_T or SET_O:
  - seg_err pulses next cycle and err_count increments, saturating at 255.
  - The partial frame is discarded, match_cnt = 0, and the FSM goes to WAIT_T.
  - Committed outputs and valid are unchanged.
- Latency: from the synchronised input edge of the ones digit in the STABLE_FRAMES-th matching frame, update appears SETTLE_CYCLES+1 cycles later. Add 2 cycles for the synchronisers.
- Width rules:
  - value is computed as tens*10+ones in ≥7-bit arithmetic; the maximum is 99.
  - Decoded digits are always ≤9, so value never overflows.
- Once valid is 1 it stays 1 until reset.

Test Plan:
- Reset, then drive tens=4 (0110011) / ones=2 (1101101) alternating every 50 clk with SETTLE_CYCLES=2, STABLE_FRAMES=4 -> after the 4th complete frame: update pulses once, tens=4, ones=2, value=42, valid=1; further frames give no update.
- After 42 is committed, switch to 4/3 for 3 frames then back to 4/2 -> no update and value stays 42; then 4 frames of 4/3 -> update pulse, value=43.
- Inject a=b=c=0,g=1 (0000001) as the ones digit in one frame -> one seg_err pulse, err_count=1, value unchanged, match count restarts (4 more good frames needed).
- Segments toggling every cycle while select=10 -> no sample, no update, no seg_err; FSM stays in SET_T until the segments stabilise.
- Select goes 10 -> 00 -> 01 (blanking between digits) -> partial frame discarded, no commit; normal 10 -> 01 frames commit 99 (1111011/1111011) as value=99.
- Assert res_n low mid-frame after 2 matching frames -> outputs 0 immediately, valid=0; after release, 4 full frames are needed before update.

Source files
------------

// File: rtl/seg_display_decoder.sv
// Two-digit multiplexed 7-segment bus monitor.
// Rebuilds the displayed value and flags illegal segment patterns.
module seg_display_decoder #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned STABLE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic [7:0] digit_seg,
  input  logic [1:0] digit_con,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] value,
  output logic       valid,
  output logic       update,
  output logic       seg_err,
  output logic [7:0] err_count
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);
  localparam logic [3:0] STABLE = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    WAIT_T,
    SET_T,
    WAIT_O,
    SET_O
  } state_t;

  logic [6:0] seg_s1_q, seg_s2_q, seg_p_q;
  logic [1:0] con_s1_q, con_s2_q, con_p_q;
  logic [3:0] settle_q, settle_d;
  state_t     state_q, state_d;
  logic [3:0] cand_t_q, cand_t_d;
  logic [7:0] frame_q, frame_d;
  logic [3:0] match_q, match_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d;
  logic [6:0] value_q, value_d;
  logic       valid_q, valid_d, update_q, update_d;
  logic       err_q, err_d;
  logic [7:0] errcnt_q, errcnt_d;

  logic       changed, sample, dig_ok, bad;
  logic [3:0] dig;
  logic [7:0] frame_new;

  // {legal, digit}; dp is already stripped
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = {1'b1, 4'd0};
      7'b0110000: decode = {1'b1, 4'd1};
      7'b1101101: decode = {1'b1, 4'd2};
      7'b1111001: decode = {1'b1, 4'd3};
      7'b0110011: decode = {1'b1, 4'd4};
      7'b1011011: decode = {1'b1, 4'd5};
      7'b1011111: decode = {1'b1, 4'd6};
      7'b1110000: decode = {1'b1, 4'd7};
      7'b1111111: decode = {1'b1, 4'd8};
      7'b1111011: decode = {1'b1, 4'd9};
      default:    decode = {1'b0, 4'd0};
    endcase
  endfunction

  always_comb begin
    changed  = (seg_s2_q != seg_p_q) || (con_s2_q != con_p_q);
    settle_d = changed ? 4'd0 :
               (settle_q == SETTLE) ? settle_q : settle_q + 4'd1;
    sample   = !changed && (settle_q == SETTLE - 4'd1);
    {dig_ok, dig} = decode(seg_s2_q);
    frame_new = {cand_t_q, dig};

    state_d  = state_q;
    cand_t_d = cand_t_q;
    frame_d  = frame_q;
    match_d  = match_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    value_d  = value_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;
    bad      = 1'b0;

    unique case (state_q)
      WAIT_T: if (con_s2_q == 2'b10) state_d = SET_T;
      SET_T: begin
        if (con_s2_q != 2'b10) begin
          state_d = WAIT_T;
        end else if (sample) begin
          if (dig_ok) begin
            cand_t_d = dig;
            state_d  = WAIT_O;
          end else begin
            bad = 1'b1;
          end
        end
      end
      WAIT_O: begin
        if (con_s2_q == 2'b01) state_d = SET_O;
        else if (con_s2_q != 2'b10) state_d = WAIT_T;
      end
      SET_O: begin
        if (con_s2_q != 2'b01) begin
          state_d = WAIT_T;
        end else if (sample) begin
          state_d = WAIT_T;
          if (!dig_ok) begin
            bad = 1'b1;
          end else begin
            if (frame_new == frame_q) begin
              match_d = (match_q == STABLE) ? match_q : match_q + 4'd1;
            end else begin
              frame_d = frame_new;
              match_d = 4'd1;
            end
            if (match_d == STABLE) begin
              tens_d   = cand_t_q;
              ones_d   = dig;
              value_d  = 7'(cand_t_q) * 7'd10 + 7'(dig);
              valid_d  = 1'b1;
              update_d = !valid_q || ({tens_q, ones_q} != frame_new);
            end
          end
        end
      end
      default: state_d = WAIT_T;
    endcase

    if (bad) begin
      state_d  = WAIT_T;
      match_d  = 4'd0;
      err_d    = 1'b1;
      errcnt_d = (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      seg_p_q  <= '0;
      con_s1_q <= '0;
      con_s2_q <= '0;
      con_p_q  <= '0;
      settle_q <= '0;
      state_q  <= WAIT_T;
      cand_t_q <= '0;
      frame_q  <= '0;
      match_q  <= '0;
      tens_q   <= '0;
      ones_q   <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      seg_s1_q <= digit_seg[7:1];
      seg_s2_q <= seg_s1_q;
      seg_p_q  <= seg_s2_q;
      con_s1_q <= digit_con;
      con_s2_q <= con_s1_q;
      con_p_q  <= con_s2_q;
      settle_q <= settle_d;
      state_q  <= state_d;
      cand_t_q <= cand_t_d;
      frame_q  <= frame_d;
      match_q  <= match_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign tens      = tens_q;
  assign ones      = ones_q;
  assign value     = value_q;
  assign valid     = valid_q;
  assign update    = update_q;
  assign seg_err   = err_q;
  assign err_count = errcnt_q;

endmodule

// File: tb/tb_seg_display_decoder.sv
// Scoreboard bench for seg_display_decoder.
// A frame model predicts commits; a monitor records update pulses.
module tb_seg_display_decoder;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic [7:0] digit_seg = '0;
  logic [1:0] digit_con = '0;
  logic [3:0] tens, ones;
  logic [6:0] value;
  logic       valid, update, seg_err;
  logic [7:0] err_count;

  seg_display_decoder #(.SETTLE_CYCLES(2), .STABLE_FRAMES(4)) dut (
    .clk(clk), .res_n(res_n),
    .digit_seg(digit_seg), .digit_con(digit_con),
    .tens(tens), .ones(ones), .value(value), .valid(valid),
    .update(update), .seg_err(seg_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] sb[$];
  logic [15:0] obs[$];
  int err_seen = 0;
  int exp_err = 0;
  int exp_cnt = 0;
  logic [7:0] m_prev = '0;
  int m_match = 0;
  logic [7:0] m_val = '0;
  logic m_valid = 1'b0;

  always @(negedge clk) begin
    if (res_n) begin
      if (update) obs.push_back({valid, tens, ones, value});
      if (seg_err) err_seen++;
    end
  end

  function automatic logic [7:0] pat(input int d);
    case (d)
      0: pat = 8'hFC;
      1: pat = 8'h60;
      2: pat = 8'hDA;
      3: pat = 8'hF2;
      4: pat = 8'h66;
      5: pat = 8'hB6;
      6: pat = 8'hBE;
      7: pat = 8'hE0;
      8: pat = 8'hFE;
      9: pat = 8'hF6;
      default: pat = 8'h02;
    endcase
  endfunction

  task automatic model_frame(input int t, input int o);
    logic [7:0] f;
    int v;
    if (o > 9) begin
      exp_err++;
      exp_cnt++;
      m_match = 0;
      return;
    end
    f = {4'(t), 4'(o)};
    if (f == m_prev) begin
      if (m_match < 4) m_match++;
    end else begin
      m_prev = f;
      m_match = 1;
    end
    if (m_match == 4) begin
      v = t * 10 + o;
      if (!m_valid || m_val != f) sb.push_back({1'b1, f, 7'(v)});
      m_val = f;
      m_valid = 1'b1;
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [7:0] s, input int n);
    digit_con = c;
    digit_seg = s;
    repeat (n) @(posedge clk);
  endtask

  task automatic frame(input int t, input int o);
    model_frame(t, o);
    drive(2'b10, pat(t) | 8'($urandom_range(0, 1)), 50);
    drive(2'b01, pat(o) | 8'($urandom_range(0, 1)), 50);
  endtask

  task automatic test_reset;
    res_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({tens, ones, value} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_value got=%h/%h/%0d want=0", tens, ones, value);
    end
    n_tests++;
    if ({valid, update, seg_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=000", {valid, update, seg_err});
    end
    n_tests++;
    if (err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_errcnt got=%0d want=0", err_count);
    end
    res_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_commit;
    logic [15:0] e, g;
    repeat (6) frame(4, 2);
    repeat (5) @(posedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests++;
      if (obs.size() == 0) begin
        n_fail++;
        $display("FAIL commit_missing got=none want=%h", e);
      end else begin
        g = obs.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL commit_42 got=%h want=%h", g, e);
        end
      end
    end
    n_tests++;
    if (obs.size() != 0) begin
      n_fail++;
      $display("FAIL commit_extra got=%0d want=0", obs.size());
    end
  endtask

  task automatic test_change;
    logic [15:0] e, g;
    repeat (3) frame(4, 3);
    frame(4, 2);
    n_tests++;
    if (obs.size() != 0 || value !== 7'd42) begin
      n_fail++;
      $display("FAIL change_early got=%0d/%0d want=0/42", obs.size(), value);
    end
    repeat (4) frame(4, 3);
    repeat (5) @(posedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests++;
      if (obs.size() == 0) begin
        n_fail++;
        $display("FAIL change_missing got=none want=%h", e);
      end else begin
        g = obs.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL change_43 got=%h want=%h", g, e);
        end
      end
    end
    n_tests++;
    if (obs.size() != 0 || value !== 7'd43) begin
      n_fail++;
      $display("FAIL change_final got=%0d/%0d want=0/43", obs.size(), value);
    end
  endtask

  task automatic test_illegal;
    logic [15:0] e, g;
    repeat (3) frame(5, 1);
    frame(4, 15);
    repeat (3) frame(5, 1);
    n_tests++;
    if (err_seen != exp_err || err_count !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL illegal_err got=%0d/%0d want=%0d", err_seen, err_count, exp_err);
    end
    n_tests++;
    if (obs.size() != 0 || value !== 7'd43 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_hold got=%0d/%0d want=0/43", obs.size(), value);
    end
    frame(5, 1);
    repeat (5) @(posedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests++;
      if (obs.size() == 0) begin
        n_fail++;
        $display("FAIL illegal_missing got=none want=%h", e);
      end else begin
        g = obs.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL illegal_51 got=%h want=%h", g, e);
        end
      end
    end
  endtask

  task automatic test_toggle;
    logic [15:0] e, g;
    model_frame(7, 7);
    for (int i = 0; i < 40; i++) begin
      digit_con = 2'b10;
      digit_seg = (i % 2 == 0) ? pat(8) : pat(15);
      @(posedge clk);
    end
    n_tests++;
    if (err_seen != exp_err || obs.size() != 0) begin
      n_fail++;
      $display("FAIL toggle_quiet got=%0d/%0d want=%0d/0", err_seen, obs.size(), exp_err);
    end
    drive(2'b10, pat(7), 50);
    drive(2'b01, pat(7), 50);
    repeat (3) frame(7, 7);
    repeat (5) @(posedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests++;
      if (obs.size() == 0) begin
        n_fail++;
        $display("FAIL toggle_missing got=none want=%h", e);
      end else begin
        g = obs.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL toggle_77 got=%h want=%h", g, e);
        end
      end
    end
  endtask

  task automatic test_blank;
    logic [15:0] e, g;
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, pat(9), 50);
      drive(2'b00, 8'h00, 20);
      drive(2'b01, pat(9), 50);
    end
    n_tests++;
    if (obs.size() != 0 || value !== 7'd77) begin
      n_fail++;
      $display("FAIL blank_discard got=%0d/%0d want=0/77", obs.size(), value);
    end
    repeat (4) frame(9, 9);
    repeat (5) @(posedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests++;
      if (obs.size() == 0) begin
        n_fail++;
        $display("FAIL blank_missing got=none want=%h", e);
      end else begin
        g = obs.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL blank_99 got=%h want=%h", g, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] e, g;
    repeat (2) frame(3, 6);
    drive(2'b10, pat(3), 20);
    #3 res_n = 1'b0;
    #1;
    n_tests++;
    if ({tens, ones, value, valid, err_count} !== 24'd0) begin
      n_fail++;
      $display("FAIL midreset_async got=%h/%h/%0d/%b/%0d want=0",
               tens, ones, value, valid, err_count);
    end
    m_prev = '0;
    m_match = 0;
    m_val = '0;
    m_valid = 1'b0;
    exp_cnt = 0;
    repeat (3) @(posedge clk);
    res_n = 1'b1;
    repeat (3) frame(3, 6);
    n_tests++;
    if (obs.size() != 0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_early got=%0d/%b want=0/0", obs.size(), valid);
    end
    frame(3, 6);
    repeat (5) @(posedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_tests++;
      if (obs.size() == 0) begin
        n_fail++;
        $display("FAIL midreset_missing got=none want=%h", e);
      end else begin
        g = obs.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL midreset_36 got=%h want=%h", g, e);
        end
      end
    end
    n_tests++;
    if (obs.size() != 0 || err_count !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL midreset_final got=%0d/%0d want=0/%0d", obs.size(), err_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_change();
    test_illegal();
    test_toggle();
    test_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
